// File: rtl/gray_to_binary_serial.sv
// Serial Gray-to-binary converter: accepts an N-bit Gray word, then resolves
// one binary bit per cycle from the MSB down. The result is held until it is
// consumed. Uses a valid/ready handshake on both the input and output sides.
module gray_to_binary_serial #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] gray_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] bin_out,
  output logic         busy
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  state_e          state_q;
  logic [N-1:0]    gray_q;
  logic [IdxW-1:0] idx_q;
  // Previously resolved binary bit b[i+1]; zero before the MSB so b[N-1] = g[N-1].
  logic            prev_q;
  logic            cur_bit;

  // Bit resolved in the current CONV cycle.
  assign cur_bit = gray_q[idx_q] ^ prev_q;

  // Handshake and status flags decode directly from the state register.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);

  // Control FSM and datapath: capture, per-bit resolve, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gray_q  <= '0;
      bin_out <= '0;
      idx_q   <= IdxTop;
      prev_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            gray_q  <= gray_in;
            bin_out <= '0;
            idx_q   <= IdxTop;
            prev_q  <= 1'b0;
            state_q <= StConv;
          end
        end
        StConv: begin
          bin_out[idx_q] <= cur_bit;
          prev_q         <= cur_bit;
          // Stop at index 0 rather than letting the counter wrap.
          if (idx_q == '0) begin
            state_q <= StDone;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Directed testbench for gray_to_binary_serial: a 16-bit instance for the
// functional, backpressure and reset scenarios, and a 4-bit instance swept
// over every code.
module tb_gray_to_binary_serial;

  logic        clk;
  logic        rst_n;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [15:0] gray_in16, bin_out16;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  gray_in4, bin_out4;

  int n_cmp;
  int n_err;
  int cyc;

  gray_to_binary_serial #(.N(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .gray_in   (gray_in16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .bin_out   (bin_out16),
    .busy      (busy16)
  );

  gray_to_binary_serial #(.N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .gray_in   (gray_in4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .bin_out   (bin_out4),
    .busy      (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive a 16-bit word and let the next edge accept it; returns #1 after that edge.
  task automatic accept16(input logic [15:0] g);
    in_valid16 = 1'b1;
    gray_in16  = g;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
  endtask

  // Wait for out_valid16 with a cycle budget; lat counts edges since the call.
  task automatic wait_done16(output int lat);
    lat = 0;
    while (!out_valid16 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready16, out_valid16, busy16} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 100", {in_ready16, out_valid16, busy16});
    end
    n_cmp++;
    if (bin_out16 !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_bin_out: got %h want 0000", bin_out16);
    end
    n_cmp++;
    if (dut16.idx_q !== 4'd15 || dut16.gray_q !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_internal: idx %0d gray %h want 15 0000", dut16.idx_q, dut16.gray_q);
    end
    n_cmp++;
    if ({in_ready4, out_valid4, busy4, bin_out4} !== 7'b100_0000) begin
      n_err++;
      $display("FAIL reset_n4: got %b want 1000000", {in_ready4, out_valid4, busy4, bin_out4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int lat;
    out_ready16 = 1'b1;
    accept16(16'h8000);
    n_cmp++;
    if ({busy16, in_ready16} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_busy: got %b want 10", {busy16, in_ready16});
    end
    wait_done16(lat);
    n_cmp++;
    if (lat !== 16) begin
      n_err++;
      $display("FAIL basic_latency: got %0d want 16", lat);
    end
    n_cmp++;
    if (bin_out16 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL basic_result: got %h want ffff", bin_out16);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready16, out_valid16, busy16} !== 3'b100 || bin_out16 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL basic_idle_hold: flags %b bin %h want 100 ffff",
               {in_ready16, out_valid16, busy16}, bin_out16);
    end
  endtask

  task automatic test_vectors;
    logic [15:0] tg [5] = '{16'h0003, 16'hC000, 16'h0000, 16'hFFFF, 16'h0001};
    logic [15:0] te [5] = '{16'h0002, 16'h8000, 16'h0000, 16'hAAAA, 16'h0001};
    int lat;
    out_ready16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      accept16(tg[i]);
      wait_done16(lat);
      n_cmp++;
      if (lat !== 16 || bin_out16 !== te[i]) begin
        n_err++;
        $display("FAIL vector_%0d: gray %h got %h lat %0d want %h lat 16",
                 i, tg[i], bin_out16, lat, te[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int bad;
    out_ready16 = 1'b0;
    accept16(16'h0003);
    // Input changes and new requests mid-conversion must be ignored.
    in_valid16 = 1'b1;
    gray_in16  = 16'hFFFF;
    wait_done16(lat);
    n_cmp++;
    if (lat !== 16 || bin_out16 !== 16'h0002) begin
      n_err++;
      $display("FAIL bp_result: got %h lat %0d want 0002 lat 16", bin_out16, lat);
    end
    gray_in16 = 16'h8000;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if ({out_valid16, in_ready16, busy16} !== 3'b101 || bin_out16 !== 16'h0002) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d unstable cycles, last flags %b bin %h want 101 0002",
               bad, {out_valid16, in_ready16, busy16}, bin_out16);
    end
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready16, busy16} !== 2'b10 || bin_out16 !== 16'h0002) begin
      n_err++;
      $display("FAIL bp_consume: flags %b bin %h want 10 0002", {in_ready16, busy16}, bin_out16);
    end
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    n_cmp++;
    if (busy16 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second_accept: busy %b want 1", busy16);
    end
    wait_done16(lat);
    n_cmp++;
    if (lat !== 16 || bin_out16 !== 16'hFFFF) begin
      n_err++;
      $display("FAIL bp_second_result: got %h lat %0d want ffff lat 16", bin_out16, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midop;
    int lat;
    out_ready16 = 1'b1;
    accept16(16'h8000);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready16, out_valid16, busy16} !== 3'b100 || bin_out16 !== 16'h0000) begin
      n_err++;
      $display("FAIL midop_reset: flags %b bin %h want 100 0000",
               {in_ready16, out_valid16, busy16}, bin_out16);
    end
    n_cmp++;
    if (dut16.idx_q !== 4'd15 || dut16.gray_q !== 16'h0000) begin
      n_err++;
      $display("FAIL midop_internal: idx %0d gray %h want 15 0000", dut16.idx_q, dut16.gray_q);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    in_valid16 = 1'b1;
    gray_in16  = 16'h0003;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    n_cmp++;
    if (busy16 !== 1'b1) begin
      n_err++;
      $display("FAIL midop_first_accept: busy %b want 1", busy16);
    end
    wait_done16(lat);
    n_cmp++;
    if (lat !== 16 || bin_out16 !== 16'h0002) begin
      n_err++;
      $display("FAIL midop_after: got %h lat %0d want 0002 lat 16", bin_out16, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_exhaustive_n4;
    int lat;
    int acc_prev;
    int bad;
    logic [3:0] v;
    bad        = 0;
    acc_prev   = 0;
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      v        = 4'(k);
      gray_in4 = v ^ (v >> 1);
      @(posedge clk);
      #1;
      if (busy4 !== 1'b1) bad++;
      if (k > 0 && (cyc - acc_prev) != 6) bad++;
      acc_prev = cyc;
      gray_in4 = ~gray_in4;
      lat = 0;
      while (!out_valid4 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if (lat !== 4 || bin_out4 !== v) begin
        n_err++;
        $display("FAIL n4_value_%0d: got %h lat %0d want %h lat 4", k, bin_out4, lat, v);
      end
      @(posedge clk);
      #1;
      if (in_ready4 !== 1'b1) bad++;
    end
    in_valid4 = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL n4_period: %0d handshake/period errors want 0", bad);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_n       = 1'b0;
    in_valid16  = 1'b0;
    gray_in16   = '0;
    out_ready16 = 1'b0;
    in_valid4   = 1'b0;
    gray_in4    = '0;
    out_ready4  = 1'b0;
    test_reset();
    test_basic();
    test_vectors();
    test_backpressure();
    test_reset_midop();
    test_exhaustive_n4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
